// File: rtl/cu_host_driver_pkg.sv
// rtl/cu_host_driver_pkg.sv - shared states and geometry constants for the CU host driver
package cu_host_driver_pkg;

  localparam int OUT_WORDS   = 16;
  localparam int ARRAY_DIM   = 4;
  localparam int DONE_MARGIN = 10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_LOAD_I0,
    S_LOAD_I1,
    S_START,
    S_WAIT_DONE,
    S_RD_ADDR,
    S_RD_CAP,
    S_EMIT
  } state_e;

endpackage

// File: rtl/cu_rd_holder.sv
// rtl/cu_rd_holder.sv - output-bank read index, capture register and valid/ready emit stage
module cu_rd_holder
  import cu_host_driver_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cap,
  input  logic [15:0] rd_data,
  input  logic        m_ready,
  output logic [15:0] rd_addr,
  output logic        m_valid,
  output logic [15:0] m_data,
  output logic        m_last,
  output logic        fire
);

  logic [15:0] idx_q, idx_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        at_last;

  assign at_last = (idx_q == 16'(OUT_WORDS - 1));
  assign fire    = valid_q && m_ready;

  always_comb begin
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (cap) begin
      data_d  = rd_data;
      valid_d = 1'b1;
    end else if (fire) begin
      // Index wraps to 0 after the final word so the next job starts clean.
      valid_d = 1'b0;
      idx_d   = at_last ? 16'd0 : idx_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= 16'd0;
      data_q  <= 16'd0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign rd_addr = idx_q;
  assign m_valid = valid_q;
  assign m_data  = data_q;
  assign m_last  = valid_q && at_last;

endmodule

// File: rtl/cu_host_driver.sv
// rtl/cu_host_driver.sv - loads one tile job into the CU, starts it and streams the 16 results back
module cu_host_driver
  import cu_host_driver_pkg::*;
#(
  parameter int K_MAX   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic [15:0] addrA,
  output logic [15:0] dataA,
  output logic        enA,
  output logic [15:0] addrB,
  output logic [15:0] dataB,
  output logic        enB,
  output logic [15:0] addrI,
  output logic [15:0] dataI,
  output logic        enI,
  output logic [15:0] addrO,
  input  logic [15:0] dataO,
  output logic        ap_start,
  input  logic        ap_done,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic        m_last,
  output logic        busy,
  output logic        err
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [15:0]       k_q, k_d;
  logic [15:0]       idx_q, idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              s_ready_q, s_ready_d;
  logic              err_q, err_d;
  logic              en_a_q, en_a_d, en_b_q, en_b_d;
  logic [15:0]       addr_a_q, addr_a_d, data_a_q, data_a_d;
  logic [15:0]       addr_b_q, addr_b_d, data_b_q, data_b_d;

  logic              accept, last_beat, hdr_ok, done_ok, rd_fire;
  logic [15:0]       words;

  assign accept    = s_valid && s_ready_q;
  assign words     = k_q * 16'(ARRAY_DIM);
  assign last_beat = (idx_q == words - 16'd1);
  assign hdr_ok    = (s_data != 16'd0) && (int'(s_data) <= K_MAX);
  // ap_done is sticky from the previous job, so it only counts after the minimum run time.
  assign done_ok   = ap_done && (int'(wait_q) >= int'(k_q) + DONE_MARGIN);

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    idx_d    = idx_q;
    wait_d   = wait_q;
    err_d    = 1'b0;
    en_a_d   = 1'b0;
    addr_a_d = addr_a_q;
    data_a_d = data_a_q;
    en_b_d   = 1'b0;
    addr_b_d = addr_b_q;
    data_b_d = data_b_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (hdr_ok) begin
            k_d     = s_data;
            idx_d   = 16'd0;
            state_d = S_LOAD_A;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD_A: begin
        if (accept) begin
          en_a_d   = 1'b1;
          addr_a_d = idx_q;
          data_a_d = s_data;
          idx_d    = last_beat ? 16'd0 : idx_q + 16'd1;
          if (last_beat) state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (accept) begin
          en_b_d   = 1'b1;
          addr_b_d = idx_q;
          data_b_d = s_data;
          idx_d    = last_beat ? 16'd0 : idx_q + 16'd1;
          if (last_beat) state_d = S_LOAD_I0;
        end
      end
      S_LOAD_I0: state_d = S_LOAD_I1;
      S_LOAD_I1: state_d = S_START;
      S_START: begin
        wait_d  = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        wait_d = wait_q + WAIT_W'(1);
        if (done_ok) begin
          state_d = S_RD_ADDR;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RD_ADDR: state_d = S_RD_CAP;
      S_RD_CAP:  state_d = S_EMIT;
      S_EMIT: begin
        if (rd_fire) state_d = m_last ? S_IDLE : S_RD_ADDR;
      end
      default: state_d = S_IDLE;
    endcase

    s_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= 16'd0;
      idx_q     <= 16'd0;
      wait_q    <= '0;
      s_ready_q <= 1'b0;
      err_q     <= 1'b0;
      en_a_q    <= 1'b0;
      addr_a_q  <= 16'd0;
      data_a_q  <= 16'd0;
      en_b_q    <= 1'b0;
      addr_b_q  <= 16'd0;
      data_b_q  <= 16'd0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      s_ready_q <= s_ready_d;
      err_q     <= err_d;
      en_a_q    <= en_a_d;
      addr_a_q  <= addr_a_d;
      data_a_q  <= data_a_d;
      en_b_q    <= en_b_d;
      addr_b_q  <= addr_b_d;
      data_b_q  <= data_b_d;
    end
  end

  cu_rd_holder u_rd_holder (
    .clk     (clk),
    .rst     (rst),
    .cap     (state_q == S_RD_CAP),
    .rd_data (dataO),
    .m_ready (m_ready),
    .rd_addr (addrO),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_last  (m_last),
    .fire    (rd_fire)
  );

  assign s_ready  = s_ready_q;
  assign err      = err_q;
  assign enA      = en_a_q;
  assign addrA    = addr_a_q;
  assign dataA    = data_a_q;
  assign enB      = en_b_q;
  assign addrB    = addr_b_q;
  assign dataB    = data_b_q;
  assign enI      = (state_q == S_LOAD_I0) || (state_q == S_LOAD_I1);
  assign addrI    = (state_q == S_LOAD_I1) ? 16'd1 : 16'd0;
  assign dataI    = (state_q == S_LOAD_I0) ? k_q : 16'd0;
  assign ap_start = (state_q == S_START);
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_cu_host_driver.sv
// tb/tb_cu_host_driver.sv - randomized self-checking bench with a behavioural CU model and scoreboard
module tb_cu_host_driver;

  localparam int K_MAX   = 16;
  localparam int TIMEOUT = 1024;

  logic        clk, rst;
  logic        s_valid, s_ready;
  logic [15:0] s_data;
  logic [15:0] addrA, dataA, addrB, dataB, addrI, dataI, addrO, dataO, m_data;
  logic        enA, enB, enI, ap_start, done_r, m_valid, m_ready, m_last, busy, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  cu_host_driver #(.K_MAX(K_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .addrA(addrA), .dataA(dataA), .enA(enA),
    .addrB(addrB), .dataB(dataB), .enB(enB),
    .addrI(addrI), .dataI(dataI), .enI(enI),
    .addrO(addrO), .dataO(dataO),
    .ap_start(ap_start), .ap_done(done_r),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // CU model: fresh random result bank per start, registered read port, programmable done.
  logic [15:0] o_mem [16];
  logic [15:0] exp_out [$];
  int          done_delay = 11;
  bit          done_sticky = 0;
  int          done_cnt = 0;
  int          start_cyc = 0;
  int          n_start = 0;
  initial done_r = 1'b0;

  always @(posedge clk) begin
    dataO <= (addrO < 16'd16) ? o_mem[addrO[3:0]] : 16'hdead;
    if (ap_start) begin
      exp_out.delete();
      for (int i = 0; i < 16; i++) begin
        o_mem[i] = 16'($urandom);
        exp_out.push_back(o_mem[i]);
      end
      start_cyc = cyc;
      n_start++;
      done_cnt <= 0;
      if (!done_sticky) done_r <= 1'b0;
    end else begin
      done_cnt <= done_cnt + 1;
      if (done_sticky || (done_delay >= 0 && done_cnt + 1 >= done_delay)) done_r <= 1'b1;
    end
  end

  // Observation scoreboard, sampled on the falling edge.
  logic [15:0] wa_addr [$], wa_data [$], wb_addr [$], wb_data [$], wi_addr [$], wi_data [$];
  logic [15:0] got [$];
  bit          got_last [$];
  int          wa_cyc [$], wb_cyc [$];
  int          n_err, n_busy, n_valid, n_out, n_stall, lat_viol, stall_viol, err_cyc, first_valid_cyc;
  bit          acc_prev, stall_prev;
  logic [15:0] st_data, st_addr;
  int          stall_word = -1;

  always @(negedge clk) begin
    if (enA) begin wa_addr.push_back(addrA); wa_data.push_back(dataA); wa_cyc.push_back(cyc); end
    if (enB) begin wb_addr.push_back(addrB); wb_data.push_back(dataB); wb_cyc.push_back(cyc); end
    if (enI) begin wi_addr.push_back(addrI); wi_data.push_back(dataI); end
    if ((enA || enB) && !acc_prev) lat_viol++;
    acc_prev = s_valid && s_ready && busy;
    if (err) begin n_err++; err_cyc = cyc; end
    if (busy) n_busy++;
    if (m_valid) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      n_valid++;
    end
    if (stall_prev && (!m_valid || m_data !== st_data || addrO !== st_addr)) stall_viol++;
    stall_prev = m_valid && !m_ready;
    st_data = m_data;
    st_addr = addrO;
    if (stall_prev) n_stall++;
    if (m_valid && m_ready) begin
      got.push_back(m_data);
      got_last.push_back(m_last);
      n_out++;
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = !(stall_word == n_out && n_stall < 5);
    end
  end

  task automatic clear_mon();
    wa_addr.delete(); wa_data.delete(); wb_addr.delete(); wb_data.delete();
    wi_addr.delete(); wi_data.delete(); got.delete(); got_last.delete();
    wa_cyc.delete(); wb_cyc.delete();
    n_err = 0; n_busy = 0; n_valid = 0; n_out = 0; n_stall = 0;
    lat_viol = 0; stall_viol = 0; err_cyc = -1; first_valid_cyc = -1;
    n_start = 0; stall_word = -1;
  endtask

  task automatic push(input logic [15:0] d, input bit gap, output bit ok);
    if (gap) begin
      s_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [136:0] all_outputs();
    return {s_ready, enA, enB, enI, ap_start, m_valid, m_last, busy, err,
            addrA, dataA, addrB, dataB, addrI, dataI, addrO, m_data};
  endfunction

  task automatic run_job(input int k, input bit gap, input int delay, input bit sticky,
                         input int stall_w, input bit seq_data);
    logic [15:0] a [$], b [$];
    bit ok;
    int pfail, bad, d;
    clear_mon();
    done_delay = delay; done_sticky = sticky; stall_word = stall_w;
    pfail = 0;
    for (int i = 0; i < 4 * k; i++) begin
      a.push_back(seq_data ? 16'(i + 1) : 16'($urandom));
      b.push_back(seq_data ? 16'(4 * k + i + 1) : 16'($urandom));
    end
    push(16'(k), 1'b0, ok); if (!ok) pfail++;
    foreach (a[i]) begin push(a[i], gap, ok); if (!ok) pfail++; end
    foreach (b[i]) begin push(b[i], gap, ok); if (!ok) pfail++; end
    wait_idle(800, ok);

    checks++;
    if (!ok || pfail != 0) begin
      errors++;
      $display("FAIL job_flow k=%0d: push_fail=%0d idle=%0d, required 0 and 1", k, pfail, ok);
    end
    bad = (wa_addr.size() != a.size()) ? 1 : 0;
    if (bad == 0) foreach (a[i]) if (wa_addr[i] !== 16'(i) || wa_data[i] !== a[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL a_writes k=%0d: %0d writes with %0d bad, required %0d in order", k, wa_addr.size(), bad, a.size());
    end
    bad = (wb_addr.size() != b.size()) ? 1 : 0;
    if (bad == 0) foreach (b[i]) if (wb_addr[i] !== 16'(i) || wb_data[i] !== b[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b_writes k=%0d: %0d writes with %0d bad, required %0d in order", k, wb_addr.size(), bad, b.size());
    end
    checks++;
    if (wi_addr.size() != 2 || wi_addr[0] !== 16'd0 || wi_data[0] !== 16'(k) ||
        wi_addr[1] !== 16'd1 || wi_data[1] !== 16'd0) begin
      errors++;
      $display("FAIL i_writes k=%0d: %0d writes, required I[0]=%0d I[1]=0", k, wi_addr.size(), k);
    end
    checks++;
    if (n_start != 1) begin
      errors++;
      $display("FAIL ap_start k=%0d: %0d pulses, required 1", k, n_start);
    end
    bad = (got.size() != 16) ? 1 : 0;
    if (bad == 0) foreach (got[i]) if (got[i] !== exp_out[i] || got_last[i] != (i == 15)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL results k=%0d: %0d words with %0d bad, required 16 matching, last on 16th", k, got.size(), bad);
    end
    checks++;
    if (n_err != 0 || lat_viol != 0 || stall_viol != 0) begin
      errors++;
      $display("FAIL job_clean k=%0d: err=%0d latency_viol=%0d stall_viol=%0d, required 0/0/0", k, n_err, lat_viol, stall_viol);
    end
    d = first_valid_cyc - start_cyc;
    checks++;
    if (first_valid_cyc < 0 || d < k + 10) begin
      errors++;
      $display("FAIL done_margin k=%0d: readback %0d cycles after start, required >= %0d", k, d, k + 10);
    end
    if (!gap) begin
      checks++;
      if (wa_cyc.size() == 0 || wb_cyc.size() == 0 || wb_cyc[0] - wa_cyc[wa_cyc.size() - 1] != 1) begin
        errors++;
        $display("FAIL ab_boundary k=%0d: enA->enB gap wrong, required 1 cycle", k);
      end
    end
    if (stall_w >= 0) begin
      checks++;
      if (n_stall != 5) begin
        errors++;
        $display("FAIL stall_len: %0d stalled cycles, required 5", n_stall);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = 16'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_outputs() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: %h, required 0", all_outputs());
    end
    rst = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_at_release: %b, required 0", s_ready);
    end
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_release: s_ready=%b busy=%b, required 1 and 0", s_ready, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_header_reject();
    bit ok0, ok1;
    clear_mon();
    push(16'd0, 1'b0, ok0);
    push(16'(K_MAX + 1), 1'b0, ok1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!ok0 || !ok1 || n_err != 2) begin
      errors++;
      $display("FAIL header_err: accepted=%0d%0d err_cycles=%0d, required 11 and 2", ok0, ok1, n_err);
    end
    checks++;
    if (n_busy != 0 || wa_addr.size() + wb_addr.size() + wi_addr.size() != 0) begin
      errors++;
      $display("FAIL header_quiet: busy_cycles=%0d writes=%0d, required 0 and 0", n_busy,
               wa_addr.size() + wb_addr.size() + wi_addr.size());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int pfail;
    clear_mon();
    done_delay = -1; done_sticky = 0;
    pfail = 0;
    push(16'd1, 1'b0, ok); if (!ok) pfail++;
    for (int i = 0; i < 8; i++) begin push(16'($urandom), 1'b0, ok); if (!ok) pfail++; end
    wait_idle(TIMEOUT + 200, ok);
    checks++;
    if (!ok || pfail != 0 || n_err != 1 || n_start != 1) begin
      errors++;
      $display("FAIL timeout_err: idle=%0d push_fail=%0d err=%0d starts=%0d, required 1/0/1/1", ok, pfail, n_err, n_start);
    end
    checks++;
    if (err_cyc - start_cyc < TIMEOUT || err_cyc - start_cyc > TIMEOUT + 4) begin
      errors++;
      $display("FAIL timeout_time: err %0d cycles after start, required %0d..%0d", err_cyc - start_cyc, TIMEOUT, TIMEOUT + 4);
    end
    checks++;
    if (n_valid != 0) begin
      errors++;
      $display("FAIL timeout_no_emit: m_valid cycles=%0d, required 0", n_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_mon();
    done_delay = 12; done_sticky = 0;
    push(16'd2, 1'b0, ok);
    for (int i = 0; i < 11; i++) push(16'($urandom), 1'b0, ok);
    checks++;
    if (enB !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_state: enB=%b busy=%b, required 1 and 1", enB, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (all_outputs() !== '0) begin
      errors++;
      $display("FAIL async_reset: %h, required 0 before any clock", all_outputs());
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: s_ready=%b busy=%b, required 1 and 0", s_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    run_job(1, 1'b0, 11, 1'b0, -1, 1'b1);
    run_job(4, 1'b1, 20, 1'b0, -1, 1'b0);
    run_job(3, 1'b0, 0, 1'b1, -1, 1'b0);
    test_header_reject();
    test_timeout();
    run_job(2, 1'b0, 12, 1'b0, 7, 1'b0);
    for (int r = 0; r < 2; r++)
      run_job(int'($urandom_range(2, K_MAX)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 40)), 1'b0, -1, 1'b0);
    run_job(K_MAX, 1'b0, 5, 1'b0, -1, 1'b0);
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
